// File: rtl/mod8191_div_arbiter_if.sv
// Request, shared-divider and response signals of the mod-8191 divider arbiter.
// The master side owns the requesters, the divider and the response sink;
// the slave side is the arbiter itself.
interface mod8191_div_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_x;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        div_x;
  logic [19:0]        div_q;
  logic [12:0]        div_r;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [19:0]        rsp_q;
  logic [12:0]        rsp_r;

  modport master (
    output req_valid, req_x, div_q, div_r, rsp_ready,
    input  req_ready, div_x, rsp_valid, rsp_id, rsp_q, rsp_r
  );

  modport slave (
    input  req_valid, req_x, div_q, div_r, rsp_ready,
    output req_ready, div_x, rsp_valid, rsp_id, rsp_q, rsp_r
  );
endinterface

// File: rtl/mod8191_div_arbiter.sv
// Round-robin arbiter sharing one combinational mod-8191 divider between
// NREQ requesters. Stage A holds the issued operand and drives the divider;
// stage B captures quotient/remainder and returns them with the requester id.
module mod8191_div_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  mod8191_div_arbiter_if.slave      bus
);

  // Stage A (issue) and stage B (response) registers
  logic           a_vld;
  logic [31:0]    a_x;
  logic [IDW-1:0] a_id;
  logic           b_vld;
  logic [19:0]    b_q;
  logic [12:0]    b_r;
  logic [IDW-1:0] b_id;
  logic [IDW-1:0] ptr;

  logic           b_free;
  logic           a_adv;
  logic           a_free;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [31:0]    gnt_x;
  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0] ptr_nxt;
  logic [32:0]    qr_fixed;

  // The divider computes internally with x+1, which wraps to zero for the
  // all-ones operand; that single case is replaced with the true result.
  function automatic logic [32:0] fix_ovf(input logic [31:0] x,
                                          input logic [19:0] q,
                                          input logic [12:0] r);
    if (x == 32'hFFFF_FFFF) return {20'h80040, 13'd63};
    return {q, r};
  endfunction

  assign b_free   = !b_vld || bus.rsp_ready;
  assign a_adv    = a_vld && b_free;
  assign a_free   = !a_vld || a_adv;
  assign qr_fixed = fix_ovf(a_x, bus.div_q, bus.div_r);
  assign ptr_nxt  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  assign bus.div_x     = a_x;
  assign bus.req_ready = gnt_oh;
  assign bus.rsp_valid = b_vld;
  assign bus.rsp_id    = b_id;
  assign bus.rsp_q     = b_q;
  assign bus.rsp_r     = b_r;

  // Round-robin search from ptr upward, wrapping at NREQ-1; no grant in reset
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    gnt_x   = '0;
    gnt_oh  = '0;
    idx     = 0;
    if (rstn && a_free) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_vld && bus.req_valid[idx]) begin
          gnt_vld     = 1'b1;
          gnt_id      = IDW'(idx);
          gnt_x       = bus.req_x[32*idx +: 32];
          gnt_oh[idx] = 1'b1;
        end
      end
    end
  end

  // Stage A: load the winner on a grant, empty when it moves on with no refill
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_vld <= 1'b0;
      a_x   <= '0;
      a_id  <= '0;
      ptr   <= '0;
    end else if (gnt_vld) begin
      a_vld <= 1'b1;
      a_x   <= gnt_x;
      a_id  <= gnt_id;
      ptr   <= ptr_nxt;
    end else if (a_adv) begin
      a_vld <= 1'b0;
    end
  end

  // Stage B: capture the divider result on A->B, empty when drained without refill
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_vld <= 1'b0;
      b_q   <= '0;
      b_r   <= '0;
      b_id  <= '0;
    end else if (a_adv) begin
      b_vld <= 1'b1;
      b_id  <= a_id;
      b_q   <= qr_fixed[32:13];
      b_r   <= qr_fixed[12:0];
    end else if (b_vld && bus.rsp_ready) begin
      b_vld <= 1'b0;
    end
  end

endmodule

// File: doc/mod8191_div_arbiter.md
Name: mod8191_div_arbiter

Overview:
- Shares one combinational mod-8191 divider between NREQ requesters. The divider computes q = x / 8191 (20 bits) and r = x mod 8191 (13 bits).
- Arbitrates round-robin and registers the winning operand into an issue stage that drives the divider.
- Captures the divider result in a response stage and returns it with the requester id under valid/ready backpressure.
- Corrects the divider's single overflow case, x = 32'hFFFFFFFF.

Parameters:
NREQ, 4, number of requesters (2..16)
IDW, 2, requester id width; 2^IDW >= NREQ

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operand valid
req_x  in  NREQ*32  packed operands, requester i at bits [32i+31:32i]
req_ready  out  NREQ  per-requester accept (one-hot or zero)
div_x  out  32  operand to shared divider
div_q  in  20  divider quotient (combinational from div_x)
div_r  in  13  divider remainder (combinational from div_x)
rsp_valid  out  1  result valid
rsp_ready  in  1  result accept
rsp_id  out  IDW  requester index of result
rsp_q  out  20  quotient
rsp_r  out  13  remainder

Behaviour:
- Two register stages:
  - Stage A (issue): a_vld, a_x, a_id.
  - Stage B (response): b_vld, b_q, b_r, b_id.
- div_x = a_x at all times, including when a_vld=0. rsp_* = stage B registers.
- Reset (rstn low, asynchronous):
  - a_vld=0, b_vld=0, a_x=0, a_id=0, b_q=0, b_r=0, b_id=0.
  - RR pointer = 0.
  - req_ready forced 0 while rstn low.
  - In-flight operations are discarded; no response is produced for them.
- Advance conditions:
  - b_free = !b_vld | rsp_ready.
  - a_adv = a_vld & b_free.
  - a_free = !a_vld | a_adv.
- Arbitration (combinational):
  - When a_free, grant the first i with req_valid[i], searching from ptr upward with wrap at NREQ-1 -> 0.
  - req_ready[grant]=1, all others 0. No grant when no valid or !a_free.
- Handshake:
  - Transfer occurs on req_valid[i] & req_ready[i]. Requesters must hold req_x stable until accepted.
  - req_ready may depend on req_valid (combinational arbiter). req_valid must not depend on req_ready.
- On a grant edge: a_x <= req_x[winner], a_id <= winner, a_vld <= 1, ptr <= winner+1 mod NREQ.
- Otherwise:
  - if a_adv, a_vld <= 0.
  - ptr unchanged when there is no grant.
- On a_adv: b_vld <= 1, b_id <= a_id.
  - If a_x == 32'hFFFFFFFF: b_q <= 20'h80040, b_r <= 13'd63. This overrides the divider, whose internal x+1 wraps.
  - Else b_q <= div_q, b_r <= div_r.
- If b_vld & rsp_ready & !a_adv: b_vld <= 0.
- Latency: accept edge -> rsp_valid high exactly 2 cycles later when rsp_ready is held high.
- Throughput: 1 result/cycle sustained with rsp_ready=1.
- Backpressure: rsp_ready=0 with B full and A full -> all req_ready=0. Stage B values are held stable until the rsp_valid&rsp_ready transfer.
- Simultaneous events:
  - B drain and A->B move in the same cycle are allowed (B reloads, stays valid).
  - An A->B move and a new grant in the same cycle are allowed (A reloads).
- At most 2 operations in flight. Result order = grant order.
- rsp_q and rsp_r are correct for every 32-bit x: rsp_q*8191 + rsp_r == x, rsp_r < 8191.

Test Plan:
- Reset, then single req 0, x=100000, rsp_ready=1 -> 2 cycles later rsp_valid=1, rsp_id=0, rsp_q=12, rsp_r=1708.
- Boundary operands sent sequentially: x=8191 -> q=1, r=0; x=16382 -> q=2, r=0; x=8190 -> q=0, r=8190; x=0 -> q=0, r=0; x=32'hFFFFFFFF -> q=20'h80040, r=63.
- All 4 requesters valid continuously, rsp_ready=1:
  - grants ordered 0,1,2,3,0,... one per cycle;
  - rsp_id sequence matches;
  - each requester gets exactly 1 of every 4 results.
- rsp_ready=0 for 5 cycles with requests pending:
  - exactly 2 accepts, then req_ready=0;
  - rsp_* stable throughout;
  - on release, results emerge in order with no loss or duplication.
- Only req 2 valid, ptr at 3 -> wrap search grants 2; ptr becomes 3. Then req 1 and 3 valid -> 3 granted first.
- Assert rstn low asynchronously with A and B full -> rsp_valid and req_ready drop immediately. After release, ptr=0 and no stale response appears.
- Random: 10k random x, random valid/ready toggling -> scoreboard x/8191 and x%8191 per id in order, zero mismatches.
